// File: rtl/uart_regfile_loader_pkg.sv
// Shared constants and types for the register-file UART link.
//   CLKS_PER_BIT_DEF : default clk cycles per UART bit. The transmit side uses the same value.
//   FRAME_BYTES_DEF  : bytes per frame (x0..x31, 4 bytes each).
//   TIMEOUT_CLKS_DEF : inter-byte idle limit. Used only when REGLOAD_TIMEOUT_EN is defined.
//   rx_state_e       : receive bit-FSM state encoding.
package uart_regfile_loader_pkg;

   localparam int CLKS_PER_BIT_DEF = 104;
   localparam int FRAME_BYTES_DEF  = 128;
   localparam int TIMEOUT_CLKS_DEF = 12000;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_regfile_loader_uart_rx.sv
// uart_rx: receives 8N1 bytes. A 2-FF synchroniser feeds a start/data/stop bit FSM.
// Optional feature macro: REGLOAD_TIMEOUT_EN. When defined, the module also exports rx_idle.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   rx        : async serial input, idle high
//   rx_data   : received byte. It is valid while rx_valid is high and holds until the next data bit.
//   rx_valid  : 1-clk pulse when a byte with a good stop bit completes
//   rx_ferr   : 1-clk pulse when the stop bit is sampled low
//   rx_start  : 1-clk pulse when a start bit is confirmed at mid-bit
//   rx_idle   : (REGLOAD_TIMEOUT_EN only) bit FSM is in IDLE
module uart_rx
   import uart_regfile_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_ferr,
   output logic       rx_start
`ifdef REGLOAD_TIMEOUT_EN
   ,
   output logic       rx_idle
`endif
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic             valid_q, valid_d, ferr_q, ferr_d, start_q, start_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sync1_d = rx;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      start_d = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // Start only on a real falling edge. A line still low after a bad stop bit
            // is ignored until it has gone high again.
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d = '0;
               if (!sync2_q) begin
                  state_d = RX_DATA;
                  start_d = 1'b1;
               end else begin
                  state_d = RX_IDLE;   // glitch: no error
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shreg_d = {sync2_q, shreg_q[7:1]};   // LSB first
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               // Return to IDLE at mid-stop so the next start edge is not missed.
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (sync2_q) valid_d = 1'b1;
               else         ferr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         start_q <= start_d;
      end
   end

   assign rx_data  = shreg_q;
   assign rx_valid = valid_q;
   assign rx_ferr  = ferr_q;
   assign rx_start = start_q;
`ifdef REGLOAD_TIMEOUT_EN
   assign rx_idle  = (state_q == RX_IDLE);
`endif

endmodule

// File: rtl/uart_regfile_loader.sv
// uart_regfile_loader: packs received UART bytes little-endian into 32-bit words and
// writes them to the register file. A frame of FRAME_BYTES bytes covers x0 upward.
// Optional feature macro: REGLOAD_TIMEOUT_EN. It aborts a partial frame after
// TIMEOUT_CLKS idle clocks between bytes.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   rx         : UART serial input, async, idle high
//   write      : 1-clk regfile write strobe. It is never raised for x0.
//   wrAddr     : register index. Holds its value between writes.
//   wrData     : assembled word. Holds its value between writes.
//   busy       : high from the first start bit of a frame until frame end or abort
//   frame_done : 1-clk pulse, issued together with the last write of a frame
//   frame_err  : 1-clk pulse on a stop-bit error or a timeout abort
module uart_regfile_loader
   import uart_regfile_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int FRAME_BYTES  = FRAME_BYTES_DEF,
   parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        write,
   output logic [4:0]  wrAddr,
   output logic [31:0] wrData,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_err
);

   localparam int IDX_W = $clog2(FRAME_BYTES);

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr, rx_start;
   logic       to_abort;

`ifdef REGLOAD_TIMEOUT_EN
   logic rx_idle;
`endif

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr),
      .rx_start (rx_start)
`ifdef REGLOAD_TIMEOUT_EN
      ,
      .rx_idle  (rx_idle)
`endif
   );

   logic [IDX_W-1:0] idx_q, idx_d;
   // Only lanes 0..2 are stored. Lane 3 goes straight into the write word.
   logic [23:0]      word_q, word_d;
   logic             write_q, write_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [31:0]      wr_data_q, wr_data_d;

`ifdef REGLOAD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Counts only while a frame is open and the bit FSM waits for a start edge.
   always_comb begin
      to_cnt_d = to_cnt_q;
      to_abort = 1'b0;
      if (rx_valid || !busy_q || !rx_idle) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
         to_cnt_d = '0;
         to_abort = 1'b1;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign to_abort = 1'b0;
`endif

   always_comb begin
      idx_d     = idx_q;
      word_d    = word_q;
      busy_d    = busy_q;
      write_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      if (rx_start) busy_d = 1'b1;

      if (rx_valid) begin
         if (idx_q[1:0] != 2'd3) begin
            word_d[8*idx_q[1:0] +: 8] = rx_data;
         end else if ((idx_q >> 2) != '0) begin
            // x0 is hardwired zero: consume its word but raise no strobe.
            write_d   = 1'b1;
            wr_addr_d = 5'(idx_q >> 2);
            wr_data_d = {rx_data, word_q};
         end
         if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
            idx_d  = '0;
            done_d = 1'b1;
            busy_d = 1'b0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      if (rx_ferr || to_abort) begin
         err_d  = 1'b1;
         idx_d  = '0;
         word_d = '0;
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         word_q    <= '0;
         write_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         word_q    <= word_d;
         write_q   <= write_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign write      = write_q;
   assign wrAddr     = wr_addr_q;
   assign wrData     = wr_data_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_uart_regfile_loader.sv
// Bench for uart_regfile_loader. It uses a short bit time and a short timeout so that
// whole 128-byte frames stay affordable. Expected words come from a byte-pattern model.
module tb_uart_regfile_loader;

   localparam int CPB = 8;
   localparam int FB  = 128;
   localparam int TO  = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic        write, busy, frame_done, frame_err;
   logic [4:0]  wrAddr;
   logic [31:0] wrData;

   uart_regfile_loader #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .rst(rst), .rx(rx), .write(write), .wrAddr(wrAddr), .wrData(wrData),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t wq[$];
   int  done_cnt = 0, done_w = 0, err_cnt = 0;
   int  total = 0, bad = 0;

   // Passive monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (write) wq.push_back({wrAddr, wrData});
         if (frame_done) begin
            done_cnt++;
            if (write && wrAddr == 5'd31) done_w++;
         end
         if (frame_err) err_cnt++;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
      logic [7:0] b;
      b = base + 8'(4 * k);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = bad_stop ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] base);
      for (int n = 0; n < FB; n++) send_byte(base + 8'(n), 1'b0);
   endtask

   // Compares the writes captured from index w0 against the model, for nf frames.
   task automatic check_writes(input string nm, input int w0, input logic [7:0] base, input int nf);
      int mism;
      mism = 0;
      for (int f = 0; f < nf; f++)
         for (int j = 0; j < 31; j++) begin
            int i;
            i = w0 + f * 31 + j;
            if (i >= wq.size()) mism++;
            else if (wq[i].a != 5'(j + 1) || wq[i].d != exp_word(base + 8'(f * 128), j + 1)) mism++;
         end
      chk({nm, " model words"}, 64'(mism), 64'd0);
   endtask

   task automatic check_frame(input string nm, input int w0, input int d0, input int dw0, input int e0,
                              input logic [7:0] base, input logic [31:0] e_w1, input logic [31:0] e_w31);
      int n;
      n = wq.size() - w0;
      chk({nm, " nwrites"}, 64'(n), 64'd31);
      if (n >= 1) chk({nm, " w1"}, {27'd0, wq[w0].a, wq[w0].d}, {27'd0, 5'd1, e_w1});
      if (n >= 31) chk({nm, " w31"}, {27'd0, wq[w0+30].a, wq[w0+30].d}, {27'd0, 5'd31, e_w31});
      check_writes(nm, w0, base, 1);
      chk({nm, " frame_done"}, 64'(done_cnt - d0), 64'd1);
      chk({nm, " done_with_last"}, 64'(done_w - dw0), 64'd1);
      chk({nm, " frame_err"}, 64'(err_cnt - e0), 64'd0);
      chk({nm, " busy_after"}, 64'(busy), 64'd0);
   endtask

   typedef struct {
      string      name;
      logic [7:0] base;
      logic [31:0] exp_w1;
      logic [31:0] exp_w31;
   } vec_t;

   vec_t tbl[2];
   int   w0, d0, dw0, e0;

   initial begin
      tbl[0] = '{"frame00", 8'h00, 32'h07060504, 32'h7F7E7D7C};
      tbl[1] = '{"frame80", 8'h80, 32'h87868584, 32'hFFFEFDFC};

      repeat (4) @(negedge clk);
      chk("rst write",  64'(write),      64'd0);
      chk("rst wrAddr", 64'(wrAddr),     64'd0);
      chk("rst wrData", 64'(wrData),     64'd0);
      chk("rst busy",   64'(busy),       64'd0);
      chk("rst done",   64'(frame_done), 64'd0);
      chk("rst err",    64'(frame_err),  64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven full frames.
      for (int v = 0; v < 2; v++) begin
         w0 = wq.size(); d0 = done_cnt; dw0 = done_w; e0 = err_cnt;
         send_frame(tbl[v].base);
         repeat (6) @(negedge clk);
         check_frame(tbl[v].name, w0, d0, dw0, e0, tbl[v].base, tbl[v].exp_w1, tbl[v].exp_w31);
         repeat (10) @(negedge clk);
      end

      // A bad stop bit on byte 6 aborts the frame. A resend loads only new bytes.
      w0 = wq.size(); e0 = err_cnt;
      for (int n = 0; n < 6; n++) send_byte(8'(n), 1'b0);
      chk("ferr busy_mid", 64'(busy), 64'd1);
      send_byte(8'h06, 1'b1);
      repeat (6) @(negedge clk);
      chk("ferr pulse", 64'(err_cnt - e0), 64'd1);
      chk("ferr busy", 64'(busy), 64'd0);
      chk("ferr nwrites", 64'(wq.size() - w0), 64'd0);
      repeat (10) @(negedge clk);
      w0 = wq.size(); d0 = done_cnt; dw0 = done_w; e0 = err_cnt;
      send_frame(8'h40);
      repeat (6) @(negedge clk);
      check_frame("resend", w0, d0, dw0, e0, 8'h40, 32'h47464544, 32'hBFBEBDBC);

      // A short low glitch produces nothing.
      w0 = wq.size(); e0 = err_cnt;
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      chk("glitch busy", 64'(busy), 64'd0);
      chk("glitch err", 64'(err_cnt - e0), 64'd0);
      chk("glitch nwrites", 64'(wq.size() - w0), 64'd0);

      // Reset in the middle of byte 9 discards the frame.
      for (int n = 0; n < 9; n++) send_byte(8'(n), 1'b0);
      chk("pre_rst wrAddr", 64'(wrAddr), 64'd1);
      chk("pre_rst wrData", 64'(wrData), 64'h07060504);
      rx = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst outs", {write, wrAddr, wrData, busy, frame_done, frame_err}, 64'd0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      w0 = wq.size(); d0 = done_cnt; dw0 = done_w; e0 = err_cnt;
      send_frame(8'h10);
      repeat (6) @(negedge clk);
      check_frame("after_rst", w0, d0, dw0, e0, 8'h10, 32'h17161514, 32'h8F8E8D8C);
      repeat (10) @(negedge clk);

      // Two frames back to back, with no idle gap between them.
      w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
      send_frame(8'h00);
      send_frame(8'h80);
      repeat (6) @(negedge clk);
      chk("b2b nwrites", 64'(wq.size() - w0), 64'd62);
      chk("b2b done", 64'(done_cnt - d0), 64'd2);
      chk("b2b err", 64'(err_cnt - e0), 64'd0);
      check_writes("b2b", w0, 8'h00, 2);
      repeat (10) @(negedge clk);

      // A partial frame followed by a long idle.
      e0 = err_cnt;
      for (int n = 0; n < 10; n++) send_byte(8'(n), 1'b0);
      repeat (TO + 10) @(negedge clk);
`ifdef REGLOAD_TIMEOUT_EN
      chk("timeout err", 64'(err_cnt - e0), 64'd1);
      chk("timeout busy", 64'(busy), 64'd0);
`else
      chk("no_timeout err", 64'(err_cnt - e0), 64'd0);
      chk("no_timeout busy", 64'(busy), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
